// File: rtl/core_boot_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : core_boot_sequencer_pkg
//  Description : Shared types and constants for the vanilla-core boot
//                sequencer: instruction/memory/network packet layouts, the
//                boot FSM state encoding and the fixed BAR/NULL packet fields.
//  Revision    : 1.0  initial release
// ============================================================================
package core_boot_sequencer_pkg;

    // Width of the rs/imm field of an instruction; also sizes the register file.
    localparam int rs_imm_size_gp = 6;

    // Network opcodes understood by the core.
    typedef enum logic [2:0] {
        NET_OP_NULL  = 3'd0,
        NET_OP_INSTR = 3'd1,
        NET_OP_REG   = 3'd2,
        NET_OP_PC    = 3'd3,
        NET_OP_BAR   = 3'd4
    } net_op_e;

    // 16-bit instruction word as carried in the low half of an image word.
    typedef struct packed {
        logic [4:0]                opcode;
        logic [4:0]                rd;
        logic [rs_imm_size_gp-1:0] rs_imm;
    } instruction_s;

    // Request into data_mem (the address travels on its own 32-bit bus).
    typedef struct packed {
        logic        valid;
        logic        wen;
        logic        yumi;
        logic        byte_not_word;
        logic [31:0] write_data;
    } mem_in_s;

    // Packet into the core's network port.
    typedef struct packed {
        logic [9:0]  ID;
        net_op_e     net_op;
        logic [4:0]  reserved;
        logic [31:0] net_data;
        logic [9:0]  net_addr;
    } net_packet_s;

    // Boot FSM states.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_STREAM = 3'd1,
        S_BAR    = 3'd2,
        S_PC     = 3'd3,
        S_NULLP  = 3'd4,
        S_RUN    = 3'd5
    } boot_state_e;

    // Fixed fields of the BAR and trailing NULL packets.
    localparam logic [9:0]  c_BAR_NET_ADDR  = 10'd24;
    localparam logic [9:0]  c_NULL_NET_ADDR = 10'd24;
    localparam logic [31:0] c_NULL_NET_DATA = 32'hFFFF_FFFE;

    // Address width needed to index an image of the given size (never 0).
    function automatic int rom_addr_width(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage : core_boot_sequencer_pkg
`default_nettype wire

// File: rtl/core_boot_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : core_boot_sequencer
//  Description : Streams a preloaded boot image out of a synchronous ROM.
//                Data words are written into data_mem, then instruction and
//                register words are sent to the core as INSTR/REG packets,
//                followed by BAR, PC and NULL packets that release the core.
//                The data-memory port belongs to the sequencer until the cycle
//                after the last data write and is then passed straight through
//                from the core.
//
//  Ports
//    clk, reset           clock, synchronous active-high reset
//    start_i              begin boot (only looked at in IDLE)
//    rom_addr_o           image word address
//    rom_data_i           image word, one cycle after rom_addr_o
//    core_mem_flat_i      core's data-memory request
//    core_mem_addr_i      core's data-memory address
//    to_mem_flat_o        request to data_mem
//    mem_addr_o           address to data_mem
//    net_packet_flat_o    registered packet to the core
//    busy_o               boot in progress
//    done_o               core released
//    run_cycles_o         cycles spent in RUN
//  Revision    : 1.0  initial release
// ============================================================================
module core_boot_sequencer
    import core_boot_sequencer_pkg::*;
#(
    parameter int          data_words_p   = 1024,
    parameter int          instr_words_p  = 1024,
    parameter int          reg_words_p    = 2**rs_imm_size_gp,
    parameter logic [9:0]  core_id_p      = 10'd1,
    parameter logic [31:0] barrier_mask_p = 32'h2,
    parameter logic [31:0] start_pc_p     = 32'h0
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   start_i,
    output logic [rom_addr_width(data_words_p+instr_words_p+reg_words_p)-1:0] rom_addr_o,
    input  logic [39:0]                            rom_data_i,
    input  logic [$bits(mem_in_s)-1:0]             core_mem_flat_i,
    input  logic [31:0]                            core_mem_addr_i,
    output logic [$bits(mem_in_s)-1:0]             to_mem_flat_o,
    output logic [31:0]                            mem_addr_o,
    output logic [$bits(net_packet_s)-1:0]         net_packet_flat_o,
    output logic                                   busy_o,
    output logic                                   done_o,
    output logic [31:0]                            run_cycles_o
);

    localparam int c_TOTAL = data_words_p + instr_words_p + reg_words_p;
    localparam int c_DI    = data_words_p + instr_words_p;
    localparam int c_AW    = rom_addr_width(c_TOTAL);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    boot_state_e      r_state;
    boot_state_e      w_state_next;

    logic [c_AW-1:0]  r_addr;     // ROM address counter
    logic             r_issue;    // still issuing ROM reads
    logic             r_pv;       // a ROM word returns this cycle
    logic [c_AW-1:0]  r_pidx;     // image index of the returning word

    net_packet_s      r_pkt;
    mem_in_s          r_mem_req;
    logic [31:0]      r_mem_addr;
    logic             r_owned;    // sequencer drives the data-memory port
    logic [31:0]      r_run_cycles;

    net_packet_s      w_pkt_next;
    mem_in_s          w_mem_req_next;
    logic [31:0]      w_mem_addr_next;
    logic             w_owned_next;

    // ------------------------------------------------------------------
    // Classification of the returning word by its image index
    // ------------------------------------------------------------------
    int               w_idx;
    logic             w_is_data;
    logic             w_is_instr;
    logic             w_is_reg;
    logic             w_past_data;
    logic             w_last_resp;
    instruction_s     w_instr;
    logic             w_unused;

    assign w_idx       = int'(r_pidx);
    assign w_is_data   = r_pv && (w_idx <  data_words_p);
    assign w_is_instr  = r_pv && (w_idx >= data_words_p) && (w_idx < c_DI);
    assign w_is_reg    = r_pv && (w_idx >= c_DI);
    assign w_past_data = r_pv && (w_idx >= data_words_p);
    assign w_last_resp = r_pv && (w_idx == c_TOTAL - 1);
    assign w_instr     = rom_data_i[15:0];
    assign w_unused    = &{1'b0, rom_data_i[39:38]};

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (start_i) w_state_next = S_STREAM;
            S_STREAM: if (w_last_resp) w_state_next = S_BAR;
            S_BAR:    w_state_next = S_PC;
            S_PC:     w_state_next = S_NULLP;
            S_NULLP:  w_state_next = S_RUN;
            S_RUN:    w_state_next = S_RUN;
            default:  w_state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs (next values of the registered packet / memory port)
    // ------------------------------------------------------------------
    always_comb begin
        w_pkt_next      = '0;
        w_mem_req_next  = '0;
        w_mem_addr_next = '0;
        w_owned_next    = r_owned;
        case (r_state)
            S_STREAM: begin
                if (w_is_data) begin
                    w_mem_req_next.valid      = 1'b1;
                    w_mem_req_next.wen        = 1'b1;
                    w_mem_req_next.yumi       = 1'b1;
                    w_mem_req_next.write_data = rom_data_i[31:0];
                    w_mem_addr_next           = 32'(w_idx * 4);
                end
                if (w_is_instr) begin
                    w_pkt_next.ID       = core_id_p;
                    w_pkt_next.net_op   = NET_OP_INSTR;
                    w_pkt_next.net_data = {16'h0, w_instr};
                    w_pkt_next.net_addr = 10'(w_idx - data_words_p);
                end else if (w_is_reg) begin
                    w_pkt_next.ID       = core_id_p;
                    w_pkt_next.net_op   = NET_OP_REG;
                    w_pkt_next.net_data = rom_data_i[31:0];
                    w_pkt_next.net_addr = {4'h0, rom_data_i[37:32]};
                end
                // The last data write has had its cycle on the port once the
                // first non-data word comes back.
                if (w_past_data) w_owned_next = 1'b0;
            end
            S_BAR: begin
                w_pkt_next.ID       = core_id_p;
                w_pkt_next.net_op   = NET_OP_BAR;
                w_pkt_next.net_data = barrier_mask_p;
                w_pkt_next.net_addr = c_BAR_NET_ADDR;
                // Covers an image with no instruction or register words.
                w_owned_next        = 1'b0;
            end
            S_PC: begin
                w_pkt_next.ID       = core_id_p;
                w_pkt_next.net_op   = NET_OP_PC;
                w_pkt_next.net_data = start_pc_p;
                w_pkt_next.net_addr = 10'd0;
            end
            S_NULLP, S_RUN: begin
                w_pkt_next.ID       = core_id_p;
                w_pkt_next.net_op   = NET_OP_NULL;
                w_pkt_next.net_data = c_NULL_NET_DATA;
                w_pkt_next.net_addr = c_NULL_NET_ADDR;
            end
            default: begin
                w_pkt_next = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // ROM address counter and one-stage valid/index pipeline
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr  <= '0;
            r_issue <= 1'b0;
            r_pv    <= 1'b0;
            r_pidx  <= '0;
        end else begin
            r_pv <= 1'b0;
            if (r_state == S_IDLE && start_i) begin
                r_addr  <= '0;
                r_issue <= 1'b1;
            end else if (r_state == S_STREAM && r_issue) begin
                r_pv   <= 1'b1;
                r_pidx <= r_addr;
                if (int'(r_addr) == c_TOTAL - 1) begin
                    r_issue <= 1'b0;
                end else begin
                    r_addr <= r_addr + 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Registered packet, memory port and run counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pkt        <= '0;
            r_mem_req    <= '0;
            r_mem_addr   <= '0;
            r_owned      <= 1'b1;
            r_run_cycles <= '0;
        end else begin
            r_pkt      <= w_pkt_next;
            r_mem_req  <= w_mem_req_next;
            r_mem_addr <= w_mem_addr_next;
            r_owned    <= w_owned_next;
            if (r_state == S_RUN) begin
                r_run_cycles <= r_run_cycles + 32'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign rom_addr_o        = r_addr;
    assign net_packet_flat_o = r_pkt;
    assign to_mem_flat_o     = r_owned ? r_mem_req  : core_mem_flat_i;
    assign mem_addr_o        = r_owned ? r_mem_addr : core_mem_addr_i;
    assign busy_o            = (r_state != S_IDLE) && (r_state != S_RUN);
    assign done_o            = (r_state == S_RUN);
    assign run_cycles_o      = r_run_cycles;

endmodule : core_boot_sequencer
`default_nettype wire

// File: tb/tb_core_boot_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_core_boot_sequencer
//  Description : Self-checking bench for core_boot_sequencer with a small
//                image (4 data, 3 instruction, 2 register words). Image
//                contents and core-side traffic are random; expected outputs
//                come from a cycle-indexed model of the boot schedule.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_core_boot_sequencer;
    import core_boot_sequencer_pkg::*;

    localparam int          c_D        = 4;
    localparam int          c_I        = 3;
    localparam int          c_R        = 2;
    localparam int          c_N        = c_D + c_I + c_R;
    localparam int          c_AW       = rom_addr_width(c_N);
    localparam logic [9:0]  c_CORE_ID  = 10'd1;
    localparam logic [31:0] c_BAR_MASK = 32'h2;
    localparam logic [31:0] c_START_PC = 32'h0;
    localparam int          c_RUN_E    = 4 + c_N;   // first edge in RUN

    logic                          clk;
    logic                          reset;
    logic                          start_i;
    logic [c_AW-1:0]               rom_addr_o;
    logic [39:0]                   rom_data_i;
    logic [$bits(mem_in_s)-1:0]    core_mem_flat_i;
    logic [31:0]                   core_mem_addr_i;
    logic [$bits(mem_in_s)-1:0]    to_mem_flat_o;
    logic [31:0]                   mem_addr_o;
    logic [$bits(net_packet_s)-1:0] net_packet_flat_o;
    logic                          busy_o;
    logic                          done_o;
    logic [31:0]                   run_cycles_o;

    logic [39:0] rom [0:c_N-1];
    int          n_checks;
    int          n_errors;

    core_boot_sequencer #(
        .data_words_p   (c_D),
        .instr_words_p  (c_I),
        .reg_words_p    (c_R),
        .core_id_p      (c_CORE_ID),
        .barrier_mask_p (c_BAR_MASK),
        .start_pc_p     (c_START_PC)
    ) u_dut (
        .clk               (clk),
        .reset             (reset),
        .start_i           (start_i),
        .rom_addr_o        (rom_addr_o),
        .rom_data_i        (rom_data_i),
        .core_mem_flat_i   (core_mem_flat_i),
        .core_mem_addr_i   (core_mem_addr_i),
        .to_mem_flat_o     (to_mem_flat_o),
        .mem_addr_o        (mem_addr_o),
        .net_packet_flat_o (net_packet_flat_o),
        .busy_o            (busy_o),
        .done_o            (done_o),
        .run_cycles_o      (run_cycles_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous boot ROM: one cycle of read latency.
    initial rom_data_i = '0;
    always @(posedge clk) begin
        rom_data_i <= (int'(rom_addr_o) < c_N) ? rom[rom_addr_o] : 40'h0;
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic net_packet_s mk_pkt(input net_op_e op, input logic [31:0] d, input logic [9:0] a);
        net_packet_s p;
        p          = '0;
        p.ID       = c_CORE_ID;
        p.net_op   = op;
        p.net_data = d;
        p.net_addr = a;
        return p;
    endfunction

    // Packet expected on the output after edge e (edge 0 samples start_i).
    function automatic net_packet_s exp_pkt(input int e);
        logic [39:0] w;
        if (e < 2 + c_D) return '0;
        if (e < 2 + c_D + c_I) begin
            w = rom[e - 2];
            return mk_pkt(NET_OP_INSTR, {16'h0, w[15:0]}, 10'(e - 2 - c_D));
        end
        if (e < 2 + c_N) begin
            w = rom[e - 2];
            return mk_pkt(NET_OP_REG, w[31:0], {4'h0, w[37:32]});
        end
        if (e == 2 + c_N) return mk_pkt(NET_OP_BAR, c_BAR_MASK, 10'd24);
        if (e == 3 + c_N) return mk_pkt(NET_OP_PC, c_START_PC, 10'd0);
        return mk_pkt(NET_OP_NULL, 32'hFFFF_FFFE, 10'd24);
    endfunction

    task automatic drive_core(input logic [31:0] addr);
        core_mem_flat_i = 36'({$urandom(), $urandom()});
        core_mem_addr_i = addr;
    endtask

    task automatic check_reset_state(input string tag);
        check_val({tag, " pkt"},      64'(net_packet_flat_o), 64'h0);
        check_val({tag, " mem"},      64'(to_mem_flat_o),     64'h0);
        check_val({tag, " mem_addr"}, 64'(mem_addr_o),        64'h0);
        check_val({tag, " busy"},     64'(busy_o),            64'h0);
        check_val({tag, " done"},     64'(done_o),            64'h0);
        check_val({tag, " run"},      64'(run_cycles_o),      64'h0);
        check_val({tag, " rom_addr"}, 64'(rom_addr_o),        64'h0);
    endtask

    // One boot from IDLE. Stops after edge abort_e if abort_e >= 0.
    task automatic run_boot(input int abort_e, input bit fixed_reg, input bit pulse_in_run);
        mem_in_s     m;
        logic [31:0] ma;
        int          last_e;
        for (int i = 0; i < c_N; i++) rom[i] = {8'($urandom()), $urandom()};
        if (fixed_reg) rom[c_D + c_I] = 40'h05_DEADBEEF;
        last_e = c_RUN_E + 8;

        @(negedge clk);
        start_i = 1'b1;
        @(posedge clk);                     // edge t0
        for (int e = 0; e <= last_e; e++) begin
            @(negedge clk);
            start_i = (pulse_in_run && e == c_RUN_E + 2);
            drive_core((e == 2 + c_D + 2) ? 32'h600D_BEEF : $urandom());
            #1;
            // Memory port: sequencer writes, idle, or core pass-through.
            m  = '0;
            ma = '0;
            if (e >= 2 && e <= 1 + c_D) begin
                m.valid      = 1'b1;
                m.wen        = 1'b1;
                m.yumi       = 1'b1;
                m.write_data = rom[e - 2][31:0];
                ma           = 32'(4 * (e - 2));
            end else if (e >= 2 + c_D) begin
                m  = core_mem_flat_i;
                ma = core_mem_addr_i;
            end
            check_val($sformatf("pkt e=%0d", e),      64'(net_packet_flat_o), 64'(exp_pkt(e)));
            check_val($sformatf("mem e=%0d", e),      64'(to_mem_flat_o),     64'(m));
            check_val($sformatf("mem_addr e=%0d", e), 64'(mem_addr_o),        64'(ma));
            check_val($sformatf("busy e=%0d", e),     64'(busy_o),            64'(e < c_RUN_E));
            check_val($sformatf("done e=%0d", e),     64'(done_o),            64'(e >= c_RUN_E));
            check_val($sformatf("run e=%0d", e),      64'(run_cycles_o),
                      64'((e >= c_RUN_E) ? (e - c_RUN_E) : 0));
            if (e < c_N)
                check_val($sformatf("rom_addr e=%0d", e), 64'(rom_addr_o), 64'(e));
            if (fixed_reg && e == 2 + c_D + c_I) begin
                check_val("reg5 net_addr", 64'(net_packet_flat_o[9:0]),  64'd5);
                check_val("reg5 net_data", 64'(net_packet_flat_o[41:10]), 64'hDEAD_BEEF);
            end
            if (e == 2 + c_D + 2)
                check_val("handover addr", 64'(mem_addr_o), 64'h600D_BEEF);
            if (e == abort_e) return;
        end
    endtask

    initial begin
        n_checks        = 0;
        n_errors        = 0;
        reset           = 1'b1;
        start_i         = 1'b0;
        core_mem_flat_i = '0;
        core_mem_addr_i = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        drive_core($urandom());
        #1 check_reset_state("por");
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive_core($urandom());
            #1 check_reset_state($sformatf("idle%0d", k));
        end

        // Full boot, with a start pulse while running.
        run_boot(-1, 1'b1, 1'b1);

        reset = 1'b1;
        @(negedge clk);
        drive_core($urandom());
        #1 check_reset_state("reset after run");
        reset = 1'b0;

        // Boot interrupted by reset in the middle of the instruction phase.
        run_boot(2 + c_D + 1, 1'b0, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        drive_core($urandom());
        #1 check_reset_state("reset mid boot");
        reset = 1'b0;

        // Fresh restart reproduces the whole sequence.
        run_boot(-1, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_core_boot_sequencer
`default_nettype wire
